fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of writers sharing one byte FIFO; legal range 2..8.
REQ-002 Parameter BURST_MAX, default 4: maximum beats per grant; legal range 1..16.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  NUM_REQ  per-writer byte-available flag.
REQ-006 req_data  input  NUM_REQ x 8  per-writer byte.
REQ-007 req_last  input  NUM_REQ  per-writer end-of-burst marker, qualified by valid.
REQ-008 req_ready  output  NUM_REQ  per-writer accept; one-hot or zero.
REQ-009 fifo_full  input  1  full flag from the shared FIFO.
REQ-010 fifo_write  output  1  write control to the FIFO.
REQ-011 fifo_wdata  output  8  write byte to the FIFO.
REQ-012 grant_id  output  clog2(NUM_REQ)  index of the current grantee; valid only while busy.
REQ-013 busy  output  1  high in state BURST.

Function
REQ-014 The FSM SHALL have two states: IDLE and BURST.
REQ-015 In IDLE with any req_valid high, the block SHALL pick a winner round-robin, starting at (last_grant+1) mod NUM_REQ; it SHALL register the winner into grant_id, clear beat_cnt, and enter BURST on the next edge.
REQ-016 Arbitration latency SHALL be exactly 1 cycle, from valid seen in IDLE to the first possible beat; no beat transfers in IDLE.
REQ-017 In BURST with grantee g: req_ready[g] = ~fifo_full; all other req_ready = 0.
REQ-018 In BURST: fifo_write = req_valid[g] & ~fifo_full; fifo_wdata = req_data[g]; both combinational from registered state.
REQ-019 A beat SHALL be a cycle with fifo_write high; beat_cnt increments per beat.
REQ-020 BURST SHALL exit to IDLE after a beat that has req_last[g] high, or after beat number BURST_MAX (beat_cnt == BURST_MAX-1), whichever comes first.
REQ-021 BURST SHALL exit to IDLE when req_valid[g] is low; this abandons the burst with no beat that cycle.
REQ-022 While fifo_full is high in BURST, the block SHALL stall: no beat, no counter change, grant held, no timeout.
REQ-023 On every BURST exit, last_grant SHALL be loaded with g, so a requester cannot win twice in a row while another requester is valid.
REQ-024 Outside BURST: fifo_write = 0, req_ready = 0, fifo_wdata = 0.
REQ-025 Wrap-around: the round-robin search SHALL wrap from NUM_REQ-1 to 0.
REQ-026 Never more than one fifo_write per cycle; fifo_write SHALL never be high while fifo_full is high.

Reset
REQ-027 On rst: state = IDLE, grant_id = 0, beat_cnt = 0, last_grant = NUM_REQ-1 (so requester 0 wins first), busy = 0, fifo_write = 0, req_ready = 0.
REQ-028 rst during BURST SHALL abort the burst at that edge; a beat presented in the same cycle is not written.

Structure
REQ-029 Shared package fifo_arb_pkg SHALL hold the state enum (IDLE, BURST), the data width constant 8, and the default NUM_REQ and BURST_MAX.
REQ-030 Sub-module rr_pick SHALL be a combinational round-robin picker: inputs req vector and last index; outputs winner index and any-valid.

Verification
REQ-031 After reset, req_valid=4'b1111, all last=0, full=0 -> grant order 0,1,2,3,0; each grant gives 4 beats; 1 idle cycle between grants.
REQ-032 Writer 2 sends 3 bytes 0xA1,0xA2,0xA3 with last on 0xA3 -> fifo_wdata is A1,A2,A3 on consecutive cycles, then IDLE; last_grant=2.
REQ-033 fifo_full held high for 5 cycles during beat 2 of a burst -> fifo_write=0 and req_ready=0 for those 5 cycles; burst then completes with 4 total beats.
REQ-034 Grantee drops valid after 1 beat -> IDLE next cycle; the next valid requester in round-robin order wins.
REQ-035 rst asserted in beat 3 of a burst -> no write that cycle; outputs at reset values the next cycle; requester 0 wins first afterwards.
REQ-036 Only writer 1 valid, continuous for 12 bytes -> three 4-beat bursts, all granted to writer 1, with every byte written in order.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the byte-FIFO write arbiter.
// Latency: none (declarations only). Backpressure: not applicable.
package fifo_arb_pkg;

    localparam int DATA_W        = 8;
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_BURST_MAX = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Writer/FIFO bundle for the write arbiter; slave = arbiter, master = writers + FIFO.
// Latency: wires only. Backpressure: fifo_full and req_ready carry it.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) ();
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]             req_last;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           fifo_full;
    logic                           fifo_write;
    logic [DATA_W-1:0]              fifo_wdata;
    logic [IDX_W-1:0]               grant_id;
    logic                           busy;

    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_write, fifo_wdata, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_write, fifo_wdata, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first valid request after i_last, wrapping to 0.
// Latency: combinational. Backpressure: none.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_any
);

    // Scan farthest-first so the nearest candidate after i_last overwrites.
    always_comb begin
        o_winner = '0;
        o_any    = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            logic [IDX_W-1:0] w_idx;
            w_idx = IDX_W'((int'(i_last) + k) % NUM_REQ);
            if (i_req[w_idx]) begin
                o_winner = w_idx;
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Arbitrates NUM_REQ byte writers onto one FIFO in round-robin bursts of up to BURST_MAX beats.
// Latency: 1 cycle grant, then one beat per cycle. Backpressure: fifo_full stalls the burst.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int BURST_MAX = DEF_BURST_MAX
) (
    input logic              clk,
    input logic              rst,
    fifo_wr_arbiter_if.slave io_bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] r_last_grant;
    logic [CNT_W-1:0] r_beat_cnt;

    logic             w_any;
    logic [IDX_W-1:0] w_winner;
    logic             w_busy;
    logic             w_g_valid;
    logic             w_beat;
    logic             w_burst_end;
    logic [NUM_REQ-1:0] w_ready;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req    (io_bus.req_valid),
        .i_last   (r_last_grant),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    assign w_busy      = (r_state == BURST);
    assign w_g_valid   = io_bus.req_valid[r_grant];
    // A beat coinciding with reset is suppressed so the FIFO never sees it.
    assign w_beat      = w_busy & w_g_valid & ~io_bus.fifo_full & ~rst;
    assign w_burst_end = io_bus.req_last[r_grant] | (r_beat_cnt == CNT_W'(BURST_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_beat_cnt   <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant    <= w_winner;
                        r_beat_cnt <= '0;
                        r_state    <= BURST;
                    end
                end
                BURST: begin
                    if (!w_g_valid) begin
                        r_state      <= IDLE;
                        r_last_grant <= r_grant;
                    end else if (w_beat) begin
                        if (w_burst_end) begin
                            r_state      <= IDLE;
                            r_last_grant <= r_grant;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_ready = '0;
        if (w_busy && !io_bus.fifo_full && !rst) begin
            w_ready[r_grant] = 1'b1;
        end
    end

    assign io_bus.req_ready  = w_ready;
    assign io_bus.fifo_write = w_beat;
    assign io_bus.fifo_wdata = w_busy ? io_bus.req_data[r_grant] : '0;
    assign io_bus.grant_id   = r_grant;
    assign io_bus.busy       = w_busy;

endmodule
